// File: rtl/dmux_np_buf_if.sv
// rtl/dmux_np_buf_if.sv - producer and consumer-side signals of the N-way word distributor
interface dmux_np_buf_if #(
   parameter int N = 4,
   parameter int D = 16,
   parameter int S = $clog2(N)
);
   logic         i_valid;
   logic         o_ready;
   logic [S-1:0] i_sel;
   logic         i_bcast;
   logic [D-1:0] i_data;
   logic [D-1:0] o_data [N-1:0];
   logic [N-1:0] o_valid;
   logic [N-1:0] i_ready;
   logic         o_err;

   modport slave (
      input  i_valid, i_sel, i_bcast, i_data, i_ready,
      output o_ready, o_data, o_valid, o_err
   );

   modport master (
      output i_valid, i_sel, i_bcast, i_data, i_ready,
      input  o_ready, o_data, o_valid, o_err
   );
endinterface

// File: rtl/dmux_np_buf.sv
// rtl/dmux_np_buf.sv - registered 1-to-N word distributor with per-channel holding slots
module dmux_np_buf #(
   parameter int N = 4,
   parameter int D = 16,
   parameter int S = $clog2(N)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   dmux_np_buf_if.slave  bus
);
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} ch_state_e;

   ch_state_e    state_q [N-1:0];
   ch_state_e    state_d [N-1:0];
   logic [D-1:0] data_q  [N-1:0];
   logic [D-1:0] data_d  [N-1:0];
   logic [N-1:0] full;
   logic [N-1:0] free;
   logic [N-1:0] pop;
   logic [N-1:0] wr;
   logic         sel_ok;
   logic         ready;
   logic         xfer;
   logic         err_q;
   logic         err_d;

   // Every select code is a real channel when N is a power of two.
   generate
      if ((1 << S) == N) begin : g_sel_full
         assign sel_ok = 1'b1;
      end else begin : g_sel_part
         assign sel_ok = (32'(bus.i_sel) < N);
      end
   endgenerate

   always_comb begin
      full = '0;
      for (int k = 0; k < N; k++) begin
         full[k] = (state_q[k] == FULL);
      end
   end

   assign free = ~full | bus.i_ready;
   assign pop  = full & bus.i_ready;

   // A dropped out-of-range word never has to wait for a slot.
   always_comb begin
      ready = 1'b1;
      if (bus.i_bcast) begin
         ready = &free;
      end else if (sel_ok) begin
         ready = free[bus.i_sel];
      end
   end

   assign xfer = bus.i_valid & ready;

   always_comb begin
      wr = '0;
      if (xfer) begin
         if (bus.i_bcast) begin
            wr = '1;
         end else if (sel_ok) begin
            wr[bus.i_sel] = 1'b1;
         end
      end
   end

   assign err_d = xfer & ~bus.i_bcast & ~sel_ok;

   // A FULL slot can only be written when it is popped in the same cycle,
   // so a refill keeps the slot FULL with no bubble.
   always_comb begin
      for (int k = 0; k < N; k++) begin
         state_d[k] = state_q[k];
         data_d[k]  = data_q[k];
         case (state_q[k])
            EMPTY:   if (wr[k]) state_d[k] = FULL;
            FULL:    if (pop[k] && !wr[k]) state_d[k] = EMPTY;
            default: state_d[k] = EMPTY;
         endcase
         if (wr[k]) begin
            data_d[k] = bus.i_data;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int k = 0; k < N; k++) begin
            state_q[k] <= EMPTY;
            data_q[k]  <= '0;
         end
         err_q <= 1'b0;
      end else begin
         for (int k = 0; k < N; k++) begin
            state_q[k] <= state_d[k];
            data_q[k]  <= data_d[k];
         end
         err_q <= err_d;
      end
   end

   assign bus.o_ready = ready;
   assign bus.o_valid = full;
   assign bus.o_data  = data_q;
   assign bus.o_err   = err_q;
endmodule

// File: tb/tb_dmux_np_buf.sv
// tb/tb_dmux_np_buf.sv - directed bench for dmux_np_buf with N=4 and N=3 instances
module tb_dmux_np_buf;
   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

   dmux_np_buf_if #(.N(4), .D(16)) b4 ();
   dmux_np_buf_if #(.N(3), .D(16)) b3 ();

   dmux_np_buf #(.N(4), .D(16)) u4 (.i_clk(clk), .i_rst_n(rst_n), .bus(b4.slave));
   dmux_np_buf #(.N(3), .D(16)) u3 (.i_clk(clk), .i_rst_n(rst_n), .bus(b3.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      rst_n = 1'b0;
      b4.i_valid = 0; b4.i_sel = '0; b4.i_bcast = 0; b4.i_data = '0; b4.i_ready = '0;
      b3.i_valid = 0; b3.i_sel = '0; b3.i_bcast = 0; b3.i_data = '0; b3.i_ready = '0;
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // fill channels 0 and 2, then reset asynchronously mid-cycle
      b4.i_valid = 1; b4.i_sel = 2'd0; b4.i_data = 16'h1111; tick();
      b4.i_sel = 2'd2; b4.i_data = 16'h2222; tick();
      b4.i_valid = 0;
      chk("pre_rst_valid", 32'(b4.o_valid), 32'h5);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_valid", 32'(b4.o_valid), 32'h0);
      chk("rst_data0", 32'(b4.o_data[0]), 32'h0);
      chk("rst_data2", 32'(b4.o_data[2]), 32'h0);
      chk("rst_err", 32'(b4.o_err), 32'h0);
      #1 rst_n = 1'b1;
      tick();

      b4.i_valid = 1; b4.i_sel = 2'd1; b4.i_data = 16'h1234; tick();
      b4.i_valid = 0;
      chk("first_wr_valid", 32'(b4.o_valid), 32'h2);
      chk("first_wr_data1", 32'(b4.o_data[1]), 32'h1234);

      b4.i_ready = 4'b0010; tick(); b4.i_ready = '0;
      chk("drain1_valid", 32'(b4.o_valid), 32'h0);

      // unicast with back-pressure on channel 3
      b4.i_valid = 1; b4.i_sel = 2'd3; b4.i_data = 16'hAAAA; tick();
      chk("wr3_valid", 32'(b4.o_valid), 32'h8);
      b4.i_data = 16'hBBBB; #1;
      chk("bp3_ready", 32'(b4.o_ready), 32'h0);
      tick();
      chk("bp3_data_hold", 32'(b4.o_data[3]), 32'hAAAA);
      b4.i_sel = 2'd0; b4.i_data = 16'hCCCC; #1;
      chk("other_ch_ready", 32'(b4.o_ready), 32'h1);
      tick();
      b4.i_valid = 0;
      chk("other_ch_valid", 32'(b4.o_valid), 32'h9);
      chk("other_ch_data0", 32'(b4.o_data[0]), 32'hCCCC);
      chk("bp3_data_still", 32'(b4.o_data[3]), 32'hAAAA);
      b4.i_ready = 4'b1111; tick(); b4.i_ready = '0;
      chk("drain_all_valid", 32'(b4.o_valid), 32'h0);

      // same-cycle refill on channel 2
      b4.i_valid = 1; b4.i_sel = 2'd2; b4.i_data = 16'h0001; tick();
      b4.i_ready = 4'b0100; b4.i_data = 16'h0002; #1;
      chk("refill_ready", 32'(b4.o_ready), 32'h1);
      chk("refill_first_word", 32'(b4.o_data[2]), 32'h0001);
      tick();
      b4.i_valid = 0;
      chk("refill_valid", 32'(b4.o_valid), 32'h4);
      chk("refill_second_word", 32'(b4.o_data[2]), 32'h0002);
      tick();
      b4.i_ready = '0;
      chk("refill_drained", 32'(b4.o_valid), 32'h0);
      chk("refill_data_hold", 32'(b4.o_data[2]), 32'h0002);

      // broadcast blocked by a stalled channel 1
      b4.i_valid = 1; b4.i_sel = 2'd1; b4.i_data = 16'h7777; tick();
      b4.i_bcast = 1; b4.i_sel = 2'd3; b4.i_data = 16'h5A5A; #1;
      chk("bcast_blocked", 32'(b4.o_ready), 32'h0);
      tick();
      chk("bcast_blocked_valid", 32'(b4.o_valid), 32'h2);
      chk("bcast_blocked_data1", 32'(b4.o_data[1]), 32'h7777);
      b4.i_ready = 4'b0010; #1;
      chk("bcast_ready", 32'(b4.o_ready), 32'h1);
      tick();
      b4.i_valid = 0; b4.i_bcast = 0; b4.i_ready = '0;
      chk("bcast_valid", 32'(b4.o_valid), 32'hF);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("bcast_data%0d", k), 32'(b4.o_data[k]), 32'h5A5A);
      end
      chk("bcast_err", 32'(b4.o_err), 32'h0);
      b4.i_ready = 4'b1111; tick(); b4.i_ready = '0;

      // streaming through all channels
      b4.i_ready = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         b4.i_valid = 1; b4.i_sel = 2'(i % 4); b4.i_data = 16'h1000 + 16'(i); #1;
         chk($sformatf("stream_ready%0d", i), 32'(b4.o_ready), 32'h1);
         tick();
         chk($sformatf("stream_data%0d", i), 32'(b4.o_data[i % 4]), 32'h1000 + 32'(i));
         chk($sformatf("stream_valid%0d", i), 32'(b4.o_valid), 32'(1 << (i % 4)));
      end
      b4.i_valid = 0;
      tick();
      b4.i_ready = '0;

      // out-of-range select on the N=3 instance
      b3.i_valid = 1; b3.i_sel = 2'd0; b3.i_data = 16'h0BEE; tick();
      b3.i_sel = 2'd3; b3.i_data = 16'hDEAD; #1;
      chk("oor_ready", 32'(b3.o_ready), 32'h1);
      tick();
      b3.i_valid = 0;
      chk("oor_err_high", 32'(b3.o_err), 32'h1);
      chk("oor_valid", 32'(b3.o_valid), 32'h1);
      chk("oor_data0", 32'(b3.o_data[0]), 32'h0BEE);
      chk("oor_data1", 32'(b3.o_data[1]), 32'h0);
      chk("oor_data2", 32'(b3.o_data[2]), 32'h0);
      tick();
      chk("oor_err_low", 32'(b3.o_err), 32'h0);

      // broadcast with a stale out-of-range select must not flag an error
      b3.i_ready = 3'b111;
      b3.i_valid = 1; b3.i_bcast = 1; b3.i_sel = 2'd3; b3.i_data = 16'h1357; tick();
      b3.i_valid = 0; b3.i_bcast = 0; b3.i_ready = '0;
      chk("bcast3_err", 32'(b3.o_err), 32'h0);
      chk("bcast3_valid", 32'(b3.o_valid), 32'h7);
      chk("bcast3_data2", 32'(b3.o_data[2]), 32'h1357);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/dmux_np_buf.md
Name: dmux_np_buf

Overview:
- Registered N-way word distributor: the opposite direction of the N-input combining gates. One D-bit input stream is routed to one of N output channels, or broadcast to all of them.
- Each output channel has a one-entry holding register with a valid/ready handshake.
- Sits between a single producer (for example, the ALU result bus) and N consumers (registers or RAM banks), and applies back-pressure to the producer.

Parameters:
- N, 4, number of output channels (2..16)
- D, 16, bit width of each word
- S, $clog2(N), width of the channel-select field (derived; do not override)

Ports:
- i_clk  input  1  system clock, rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_valid  input  1  producer has a word
- o_ready  output  1  block accepts the word this cycle
- i_sel  input  S  destination channel index
- i_bcast  input  1  write the word to all N channels (i_sel ignored)
- i_data  input  D  input word
- o_data  output  [D-1:0] x N (unpacked [N-1:0])  per-channel held word
- o_valid  output  N  per-channel word-valid
- i_ready  input  N  per-channel consumer ready
- o_err  output  1  one-cycle pulse: an out-of-range select was accepted and dropped

Behaviour:
- Reset (asynchronous, i_rst_n=0):
  - o_valid=0, all o_data=0, o_err=0, immediately and independent of i_clk.
  - Any in-flight words are lost.
  - Deassertion takes effect at the next rising edge.
- Per-channel state machine:
  - Two states, EMPTY (o_valid[k]=0) and FULL (o_valid[k]=1).
  - Pop: o_valid[k] & i_ready[k] at a rising edge.
  - Write: an accepted transfer that targets channel k.
  - EMPTY + write -> FULL, o_data[k]<=i_data.
  - FULL + pop, no write -> EMPTY; o_data[k] holds its last value.
  - FULL + pop + write -> stays FULL, o_data[k]<=new word (same-cycle refill, no bubble).
  - FULL + no pop -> stays FULL, data stable. A write cannot target this channel because o_ready is low.
- Slot free: free[k] = ~o_valid[k] | i_ready[k]. This is a combinational path from i_ready to o_ready.
- o_ready (combinational):
  - i_bcast=1: AND of free[k] over all k.
  - i_bcast=0, i_sel<N: free[i_sel].
  - i_bcast=0, i_sel>=N: 1. Only possible when N is not a power of 2.
- Transfer: occurs at a rising edge with i_valid & o_ready. o_ready does not depend on i_valid.
- Write targets:
  - i_bcast=1: all N channels load the same i_data.
  - Otherwise: only channel i_sel loads.
- Latency: a word accepted at edge t is visible on o_data/o_valid immediately after edge t, i.e. one cycle of latency and no combinational data path from input to output.
- Out-of-range select:
  - Applies when i_valid & ~i_bcast & i_sel>=N.
  - The word is accepted and discarded; no channel changes.
  - o_err is registered and high for exactly the cycle after the transfer, then returns to 0 unless the next transfer is also out of range.
- i_bcast=1 never raises o_err.
- Inputs are sampled only at transfer edges. While i_valid=0, i_sel, i_bcast and i_data are don't-care.
- Consumers of different channels are independent. Stalling one channel never blocks writes to other channels, except broadcasts.
- Throughput: one word per cycle when the targeted consumers are ready.

Test Plan:
- Reset state: N=4, D=16, hold i_rst_n=0 mid-run with channels 0 and 2 FULL -> o_valid=4'b0000, o_data all 0, o_err=0 with no clock edge; after release, the first write of 16'h1234 to channel 1 gives o_valid=4'b0010 after one edge.
- Unicast plus back-pressure: write 16'hAAAA to channel 3 with i_ready[3]=0, then offer 16'hBBBB to channel 3 -> o_ready=0, o_data[3] stays 16'hAAAA; offer 16'hCCCC to channel 0 in the same stall -> o_ready=1, o_valid=4'b1001.
- Same-cycle refill: channel 2 FULL with 16'h0001, i_ready[2]=1, write 16'h0002 to channel 2 -> o_valid[2] stays 1 and o_data[2]=16'h0002 next cycle; the consumer sees both words and there is no bubble.
- Broadcast: with channel 1 FULL and i_ready[1]=0, i_bcast=1 with 16'h5A5A -> o_ready=0; raise i_ready[1] -> transfer happens, and all four o_data=16'h5A5A with o_valid=4'b1111.
- Out-of-range select: N=3, write to i_sel=3 with 16'hDEAD -> o_ready=1, o_err high for exactly one cycle, and o_valid/o_data unchanged.
- Streaming: 8 back-to-back words cycling through channels 0..3, all i_ready=1 -> o_ready stays 1 throughout, and each o_data[k] matches its word one cycle after acceptance.
